// File: rtl/avgr_stream.sv
// Streaming block averager: accumulates 2^LOG2_N samples over valid/ready and
// presents their mean on a held, handshaked output. Build option: AVGR_ROUND_EN (round half-up).
module avgr_stream #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_avg,
    output logic [LOG2_N-1:0] fill
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] FILL_LAST = '1;

`ifdef AVGR_ROUND_EN
    localparam logic [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (LOG2_N - 1);
`else
    localparam logic [ACC_W-1:0] RND_BIAS = '0;
`endif

    generate
        if (DATA_W < 2 || DATA_W > 32 || LOG2_N < 1 || LOG2_N > 8) begin : g_bad_params
            $error("avgr_stream: DATA_W must be 2..32 and LOG2_N must be 1..8");
        end
    endgenerate

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Widen a sample to accumulator width according to its signedness.
    function automatic logic [ACC_W-1:0] f_ext(input logic [DATA_W-1:0] d);
        if (SIGNED != 0) begin
            return {{LOG2_N{d[DATA_W-1]}}, d};
        end
        return {{LOG2_N{1'b0}}, d};
    endfunction

    // The bias cannot overflow: the largest block sum leaves at least N codes of headroom.
    function automatic logic [DATA_W-1:0] f_mean(input logic [ACC_W-1:0] sum);
        logic        [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        biased = sum + RND_BIAS;
        if (SIGNED != 0) begin
            shifted = $signed(biased) >>> LOG2_N;
        end else begin
            shifted = $signed(biased >> LOG2_N);
        end
        return DATA_W'(shifted);
    endfunction

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [LOG2_N-1:0]   r_fill;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_avg;

    state_t              w_state_nxt;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [LOG2_N-1:0]   w_fill_nxt;
    logic                w_ov_nxt;
    logic [DATA_W-1:0]   w_avg_nxt;
    logic [ACC_W-1:0]    w_sum;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_out_fire;

    assign w_in_ready = (r_state == ST_HOLD) ? out_ready : 1'b1;
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_sum      = r_acc + f_ext(in_data);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_fill_nxt  = r_fill;
        w_ov_nxt    = r_out_valid;
        w_avg_nxt   = r_avg;

        case (r_state)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (r_fill == FILL_LAST) begin
                        w_avg_nxt   = f_mean(w_sum);
                        w_ov_nxt    = 1'b1;
                        w_acc_nxt   = '0;
                        w_fill_nxt  = '0;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_acc_nxt  = w_sum;
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_out_fire) begin
                    w_ov_nxt    = 1'b0;
                    w_state_nxt = ST_ACCUM;
                    // A sample taken while the result drains opens the next block.
                    if (w_accept) begin
                        w_acc_nxt  = f_ext(in_data);
                        w_fill_nxt = LOG2_N'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase

        if (clear) begin
            w_acc_nxt   = '0;
            w_fill_nxt  = '0;
            w_ov_nxt    = 1'b0;
            w_state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_avg       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_fill      <= w_fill_nxt;
            r_out_valid <= w_ov_nxt;
            r_avg       <= w_avg_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_avg   = r_avg;
    assign fill      = r_fill;

endmodule

// File: tb/tb_avgr_stream.sv
// Scoreboard bench for avgr_stream: unsigned and signed instances share stimulus;
// expected means are queued at stimulus time and popped by per-instance monitors.
module tb_avgr_stream;

`ifdef AVGR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        u_in_ready, u_out_valid;
    logic [15:0] u_out_avg;
    logic [3:0]  u_fill;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_avg;
    logic [3:0]  s_fill;

    int n_chk;
    int n_fail;
    logic [15:0] q_u[$];
    logic [15:0] q_s[$];

    avgr_stream #(.DATA_W(16), .LOG2_N(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_avg(u_out_avg),
        .fill(u_fill)
    );

    avgr_stream #(.DATA_W(16), .LOG2_N(4), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_avg(s_out_avg),
        .fill(s_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output-event monitors: compare whatever the consumer takes at the next edge.
    always @(negedge clk) begin
        if (rst_n && u_out_valid && out_ready) begin
            if (q_u.size() == 0) begin
                chk("unsigned_unexpected_output", u_out_avg, 32'hDEAD_BEEF);
            end else begin
                chk("unsigned_out_avg", u_out_avg, q_u.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && out_ready) begin
            if (q_s.size() == 0) begin
                chk("signed_unexpected_output", s_out_avg, 32'hDEAD_BEEF);
            end else begin
                chk("signed_out_avg", s_out_avg, q_s.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] eu, input logic [15:0] es);
        q_u.push_back(eu);
        q_s.push_back(es);
    endtask

    task automatic send(input logic [15:0] d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!u_in_ready && g < 64) begin
            step();
            g++;
        end
        if (!u_in_ready) begin
            chk("send_ready_timeout", 32'(u_in_ready), 32'd1);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_n(input logic [15:0] d, input int cnt);
        for (int i = 0; i < cnt; i++) send(d);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #22;
        chk("reset_out_valid", 32'(u_out_valid), 32'd0);
        chk("reset_fill", 32'(u_fill), 32'd0);
        chk("reset_out_avg", 32'(u_out_avg), 32'd0);
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", 32'(u_in_ready), 32'd1);

        // Samples 1..16: sum 136.
        push(RND ? 16'd9 : 16'd8, RND ? 16'd9 : 16'd8);
        for (int i = 1; i <= 15; i++) send(16'(i));
        chk("fill_15", 32'(u_fill), 32'd15);
        chk("no_early_valid", 32'(u_out_valid), 32'd0);
        send(16'd16);
        chk("latency_valid", 32'(u_out_valid), 32'd1);
        chk("latency_fill_wrap", 32'(u_fill), 32'd0);

        // Back-to-back blocks: first sample is taken while the prior result drains.
        push(16'hFFFF, 16'hFFFF);
        send_n(16'hFFFF, 16);
        push(RND ? 16'h1000 : 16'h0FFF, RND ? 16'h0000 : 16'hFFFF);
        send_n(16'h0000, 15);
        send(16'hFFFF);
        push(16'h8000, 16'h8000);
        send_n(16'h8000, 16);
        idle();
        chk("drained_valid", 32'(u_out_valid), 32'd0);

        // Backpressure hold.
        out_ready = 1'b0;
        push(16'd4, 16'd4);
        send_n(16'd4, 16);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(u_out_valid), 32'd1);
            chk("hold_avg", 32'(u_out_avg), 32'd4);
            chk("hold_in_ready", 32'(u_in_ready), 32'd0);
            idle();
        end
        push(16'd5, 16'd5);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd5;
        step();
        in_valid = 1'b0;
        chk("release_valid", 32'(u_out_valid), 32'd0);
        chk("release_fill", 32'(u_fill), 32'd1);
        send_n(16'd5, 15);
        idle();

        // Clear mid-block with a sample on the same cycle.
        send_n(16'd9, 7);
        chk("pre_clear_fill", 32'(u_fill), 32'd7);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd100;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_fill", 32'(u_fill), 32'd0);
        push(16'd6, 16'd6);
        send_n(16'd6, 16);
        idle();

        // Clear while holding a result.
        out_ready = 1'b0;
        send_n(16'd7, 16);
        chk("hold_before_clear", 32'(u_out_valid), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_hold_valid", 32'(u_out_valid), 32'd0);
        chk("clear_hold_in_ready", 32'(u_in_ready), 32'd1);
        out_ready = 1'b1;
        push(16'd3, 16'd3);
        send_n(16'd3, 16);
        idle();

        // Async reset mid-block.
        send_n(16'd1, 9);
        chk("pre_reset_fill", 32'(u_fill), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_fill", 32'(u_fill), 32'd0);
        chk("async_reset_avg", 32'(u_out_avg), 32'd0);
        #2;
        rst_n = 1'b1;
        step();

        // Async reset while holding a result.
        out_ready = 1'b0;
        send_n(16'd8, 16);
        chk("hold_before_reset", 32'(u_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(u_out_valid), 32'd0);
        chk("async_reset_hold_avg", 32'(u_out_avg), 32'd0);
        chk("async_reset_signed_valid", 32'(s_out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        push(16'd2, 16'd2);
        send_n(16'd2, 16);
        idle();
        idle();

        chk("unsigned_queue_empty", 32'(q_u.size()), 32'd0);
        chk("signed_queue_empty", 32'(q_s.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
